// File: rtl/timer_irq.sv
// Memory-mapped interval timer: prescaled reloadable up-counter with a sticky
// interrupt status bit, plus a free-running cycle counter, on the data bus.
module timer_irq #(
  parameter logic [31:0] BASE = 32'h4000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irqout
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [31:0] presc_q, presc_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [31:0] systick_q, systick_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        st_q, st_d;

  logic sel_th, sel_tl, sel_tcon, sel_presc, sel_systick;
  logic tick, ovf;

  always_comb begin
    sel_th      = (addr == BASE);
    sel_tl      = (addr == BASE + 32'h04);
    sel_tcon    = (addr == BASE + 32'h08);
    sel_presc   = (addr == BASE + 32'h0C);
    sel_systick = (addr == BASE + 32'h14);

    tick = en_q && (pcnt_q == presc_q);
    ovf  = tick && (tl_q == 32'hFFFF_FFFF);

    th_d      = th_q;
    tl_d      = tl_q;
    presc_d   = presc_q;
    pcnt_d    = pcnt_q;
    en_d      = en_q;
    ie_d      = ie_q;
    st_d      = st_q;
    systick_d = systick_q + 32'd1;

    if (!en_q || tick) pcnt_d = 32'd0;
    else               pcnt_d = pcnt_q + 32'd1;

    // Reload reads th_q, so a TH write in the overflow cycle only affects the next reload.
    if (tick) tl_d = ovf ? th_q : tl_q + 32'd1;

    if (wr) begin
      if (sel_th)    th_d = wdata;
      if (sel_tl)    tl_d = wdata;
      if (sel_presc) presc_d = wdata;
      if (sel_tcon) begin
        en_d = wdata[0];
        ie_d = wdata[1];
        st_d = st_q & wdata[2];
      end
      if (sel_presc || sel_tcon) pcnt_d = 32'd0;
    end

    // Applied last so a hardware overflow beats a same-cycle software clear.
    if (ovf && ie_q) st_d = 1'b1;
  end

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      if (sel_th)      rdata = th_q;
      if (sel_tl)      rdata = tl_q;
      if (sel_tcon)    rdata = {29'd0, st_q, ie_q, en_q};
      if (sel_presc)   rdata = presc_q;
      if (sel_systick) rdata = systick_q;
    end
  end

  assign irqout = ie_q & st_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      presc_q   <= 32'd0;
      pcnt_q    <= 32'd0;
      systick_q <= 32'd0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      st_q      <= 1'b0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      presc_q   <= presc_d;
      pcnt_q    <= pcnt_d;
      systick_q <= systick_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      st_q      <= st_d;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Directed table-driven bench for timer_irq: one row per clock cycle, outputs
// compared at the falling edge, state changes committed at the next rising edge.
module tb_timer_irq;

  localparam logic [31:0] A_TH  = 32'h4000_0000;
  localparam logic [31:0] A_TL  = 32'h4000_0004;
  localparam logic [31:0] A_TC  = 32'h4000_0008;
  localparam logic [31:0] A_PR  = 32'h4000_000C;
  localparam logic [31:0] A_GAP = 32'h4000_0010;
  localparam logic [31:0] A_ST  = 32'h4000_0014;
  localparam int NV = 50;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd, wr;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        irqout;

  int checks = 0;
  int passed = 0;
  vec_t tbl [NV];

  timer_irq #(.BASE(32'h4000_0000)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irqout(irqout)
  );

  always #5 clk = ~clk;

  function automatic vec_t rv(input logic [31:0] a, input logic [31:0] e, input logic irq);
    vec_t v;
    v.rd = 1'b1; v.wr = 1'b0; v.addr = a; v.wdata = 32'd0; v.exp_rdata = e; v.exp_irq = irq;
    return v;
  endfunction

  function automatic vec_t wv(input logic [31:0] a, input logic [31:0] d, input logic irq);
    vec_t v;
    v.rd = 1'b0; v.wr = 1'b1; v.addr = a; v.wdata = d; v.exp_rdata = 32'd0; v.exp_irq = irq;
    return v;
  endfunction

  // Drive one cycle, compare at the falling edge, then let the rising edge commit.
  task automatic apply(input string name, input logic rst_n, input vec_t v);
    reset = rst_n; rd = v.rd; wr = v.wr; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    checks++;
    if (rdata === v.exp_rdata) passed++;
    else $display("FAIL %s rdata: got %h expected %h", name, rdata, v.exp_rdata);
    checks++;
    if (irqout === v.exp_irq) passed++;
    else $display("FAIL %s irqout: got %b expected %b", name, irqout, v.exp_irq);
    $display("%s rd=%b wr=%b addr=%h wdata=%h rdata=%h irq=%b", name, v.rd, v.wr, v.addr, v.wdata, rdata, irqout);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values and basic decode; row index equals SYSTICK value.
    tbl[0]  = rv(A_ST, 32'd0, 1'b0);
    tbl[1]  = rv(A_TH, 32'd0, 1'b0);
    tbl[2]  = rv(A_TL, 32'd0, 1'b0);
    tbl[3]  = rv(A_TC, 32'd0, 1'b0);
    tbl[4]  = rv(A_PR, 32'd0, 1'b0);
    tbl[5]  = rv(A_GAP, 32'd0, 1'b0);
    tbl[6]  = rv(A_ST, 32'd6, 1'b0);
    // Basic overflow with IE on
    tbl[7]  = wv(A_PR, 32'd0, 1'b0);
    tbl[8]  = wv(A_TH, 32'hFFFF_FFFC, 1'b0);
    tbl[9]  = wv(A_TL, 32'hFFFF_FFFE, 1'b0);
    tbl[10] = wv(A_TC, 32'd3, 1'b0);
    tbl[11] = rv(A_TL, 32'hFFFF_FFFE, 1'b0);
    tbl[12] = rv(A_TL, 32'hFFFF_FFFF, 1'b0);
    tbl[13] = rv(A_TL, 32'hFFFF_FFFC, 1'b1);
    tbl[14] = rv(A_TC, 32'd7, 1'b1);
    tbl[15] = rv(A_TH, 32'hFFFF_FFFC, 1'b1);
    tbl[16] = wv(A_TH, 32'hFFFF_FFFC, 1'b1);
    tbl[16].wr = 1'b0;
    tbl[17] = wv(A_TC, 32'd3, 1'b1);
    tbl[18] = rv(A_TC, 32'd3, 1'b0);
    // Software clear on the overflow edge loses to the overflow
    tbl[19] = rv(A_TL, 32'hFFFF_FFFE, 1'b0);
    tbl[20] = wv(A_TC, 32'd3, 1'b0);
    tbl[21] = rv(A_TC, 32'd7, 1'b1);
    tbl[22] = wv(A_TC, 32'd3, 1'b1);
    tbl[23] = wv(A_TC, 32'd0, 1'b0);
    tbl[24] = rv(A_TL, 32'hFFFF_FFFF, 1'b0);
    // Overflow with IE off
    tbl[25] = wv(A_TC, 32'd1, 1'b0);
    tbl[26] = rv(A_TL, 32'hFFFF_FFFF, 1'b0);
    tbl[27] = rv(A_TL, 32'hFFFF_FFFC, 1'b0);
    tbl[28] = rv(A_TC, 32'd1, 1'b0);
    tbl[29] = wv(A_TC, 32'd0, 1'b0);
    // Prescaler of 3, with a mid-period restart
    tbl[30] = wv(A_PR, 32'd3, 1'b0);
    tbl[31] = wv(A_TL, 32'd0, 1'b0);
    tbl[32] = wv(A_TC, 32'd1, 1'b0);
    tbl[33] = rv(A_TL, 32'd0, 1'b0);
    tbl[34] = rv(A_TL, 32'd0, 1'b0);
    tbl[35] = rv(A_PR, 32'd3, 1'b0);
    tbl[36] = rv(A_TL, 32'd0, 1'b0);
    tbl[37] = rv(A_TL, 32'd1, 1'b0);
    tbl[38] = rv(A_TL, 32'd1, 1'b0);
    tbl[39] = wv(A_PR, 32'd3, 1'b0);
    tbl[40] = rv(A_TL, 32'd1, 1'b0);
    tbl[41] = rv(A_TL, 32'd1, 1'b0);
    tbl[42] = rv(A_TL, 32'd1, 1'b0);
    tbl[43] = rv(A_TL, 32'd1, 1'b0);
    tbl[44] = rv(A_TL, 32'd2, 1'b0);
    // Bus write to TL beats the tick on the same edge
    tbl[45] = rv(A_TL, 32'd2, 1'b0);
    tbl[46] = rv(A_TL, 32'd2, 1'b0);
    tbl[47] = wv(A_TL, 32'd5, 1'b0);
    tbl[48] = rv(A_TL, 32'd5, 1'b0);
    tbl[49] = rv(A_ST, 32'd49, 1'b0);

    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) apply($sformatf("vec%0d", i), 1'b1, tbl[i]);

    // TH written in the overflow cycle: reload takes the old TH
    apply("th_ovf_stop",  1'b1, wv(A_TC, 32'd0, 1'b0));
    apply("th_ovf_presc", 1'b1, wv(A_PR, 32'd0, 1'b0));
    apply("th_ovf_th",    1'b1, wv(A_TH, 32'd10, 1'b0));
    apply("th_ovf_tl",    1'b1, wv(A_TL, 32'hFFFF_FFFE, 1'b0));
    apply("th_ovf_en",    1'b1, wv(A_TC, 32'd1, 1'b0));
    apply("th_ovf_pre",   1'b1, rv(A_TL, 32'hFFFF_FFFE, 1'b0));
    apply("th_ovf_wr",    1'b1, wv(A_TH, 32'd20, 1'b0));
    apply("th_ovf_tl_rd", 1'b1, rv(A_TL, 32'd10, 1'b0));
    apply("th_ovf_th_rd", 1'b1, rv(A_TH, 32'd20, 1'b0));

    // Reset while irqout is high
    apply("rst_ie_on",  1'b1, wv(A_TC, 32'd3, 1'b0));
    apply("rst_tl_max", 1'b1, wv(A_TL, 32'hFFFF_FFFF, 1'b0));
    apply("rst_pre",    1'b1, rv(A_TL, 32'hFFFF_FFFF, 1'b0));
    apply("rst_irq_hi", 1'b1, rv(A_TL, 32'd20, 1'b1));
    apply("rst_edge",   1'b0, rv(A_TC, 32'd7, 1'b1));
    apply("rst_systick", 1'b1, rv(A_ST, 32'd0, 1'b0));
    apply("rst_tcon",   1'b1, rv(A_TC, 32'd0, 1'b0));
    apply("rst_tl",     1'b1, rv(A_TL, 32'd0, 1'b0));
    apply("rst_th",     1'b1, rv(A_TH, 32'd0, 1'b0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/timer_irq.md
# timer_irq

Memory-mapped interval timer that is the source of the `IRQ` input consumed by the single-cycle CPU's control decoder. It counts a reloadable 32-bit register upward, reloads on overflow, latches an interrupt status bit and holds `irqout` high until kernel software clears it. The block sits on the data-memory bus beside data RAM, decoded at `0x4000_0000`–`0x4000_0014`. It also provides a free-running cycle counter.

## Interface
- `BASE`, default `32'h4000_0000`: base address of the register window.
- `clk`  in  1: system clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `rd`  in  1: bus read strobe (the CPU's MemRead).
- `wr`  in  1: bus write strobe (the CPU's MemWrite).
- `addr`  in  32: byte address (the ALU result).
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, combinational.
- `irqout`  out  1: interrupt request to the CPU's `IRQ` input.

## Operation
- Register map (word offsets; only exact aligned matches decode):
  - +0x00 TH: reload value, R/W.
  - +0x04 TL: counter, R/W.
  - +0x08 TCON: bit0 EN, bit1 IE, bit2 ST; bits 31:3 read 0.
  - +0x0C PRESC: prescale divisor, R/W.
  - +0x14 SYSTICK: read-only free-running cycle count; writes are ignored.
  - Any other address reads 0, and writes to it are ignored.
- `rdata` is the selected register when `rd`=1, otherwise 0.
- Writes take effect at the edge on which `wr`=1.
- TCON write behaviour:
  - EN and IE are loaded from `wdata[1:0]`.
  - `ST <= ST & wdata[2]`, so writing 0 clears ST and writing 1 leaves it unchanged. Software cannot set ST.
- Prescaler:
  - Internal 32-bit `pcnt`.
  - When EN=1: `tick = (pcnt == PRESC)`. On tick, `pcnt <= 0`; otherwise `pcnt <= pcnt+1`.
  - When EN=0: `pcnt` is held at 0 and there is no tick.
  - Any write to PRESC or TCON forces `pcnt <= 0`.
- Counter update on tick:
  - If TL == `32'hFFFF_FFFF`: reload `TL <= TH` (overflow). If IE=1, set ST; if IE=0, ST is unchanged.
  - Otherwise: `TL <= TL+1`, with 32-bit wrap.
- `irqout = IE & ST`, combinational from the registers.
- Priorities within one edge:
  - A bus write to TL overrides the tick update of TL.
  - An overflow setting ST overrides a same-cycle software clear of ST, so no interrupt is lost.
  - A bus write to TH in the overflow cycle: the reload uses the old TH.
- SYSTICK increments by 1 every cycle regardless of EN and wraps at 2^32.
- After reset, every register, `pcnt` and SYSTICK are 0. `irqout`=0 and `rdata`=0 while `rd`=0.

## Timing
- Read latency is 0 cycles (same cycle as `addr`/`rd`), which matches the single-cycle load path.
- Write latency is 1 edge.
- With PRESC=P, TL advances once every P+1 cycles while EN=1. The first tick comes P+1 edges after the edge that set EN.
- `irqout` rises in the cycle after the overflow edge. It stays high until the ST-clear edge or the IE-clear edge, then falls in the following cycle.
- Reset asserted on any edge, including mid-count or with `irqout` high, zeroes all state at that edge. `irqout` is low in the next cycle.
- There is no handshake with the CPU beyond level-sensitive `irqout`. The CPU masks the interrupt via its kernel-mode bit, not via this block.

## Test plan
- **Reset:** hold `reset`=0 for 2 cycles, then read every address → all read 0, `irqout`=0; read 0x4000_0010 → 0.
- **Basic overflow:** PRESC=0, TH=`FFFF_FFFC`, TL=`FFFF_FFFE`, TCON=3 → TL reads `FFFF_FFFF` after 1 edge and `FFFF_FFFC` after 2 edges; ST=1 and `irqout`=1 in the next cycle; TL continues `FFFF_FFFD` after that.
- **Prescaler:** PRESC=3, TL=0, TCON=1 → TL=1 after 4 edges, 2 after 8 edges; writing PRESC mid-count restarts the 4-cycle period.
- **IE off:** TCON=1 with overflow as in the basic case → TL reloads, ST stays 0, `irqout` stays 0.
- **Simultaneous clear and overflow:** write TCON=3 (ST clear) on the same edge as an overflow with IE=1 → ST=1 and `irqout` remains 1. A later TCON=3 write clears it, and `irqout`=0 one cycle later.
- **Write priority and reset mid-count:**
  - Write TL=5 on a tick edge → TL reads 5.
  - Assert reset while `irqout`=1 → `irqout`=0 next cycle; SYSTICK restarts from 0.
